fifo_rd_ctrl: RTL and testbench

Read-domain controller for the asynchronous FIFO. It holds the read pointer in binary and Gray form, and synchronizes the write-domain Gray pointer into the read clock through a flop chain. It also decodes that pointer back to binary and produces the registered `empty` flag, fill level and underflow indication. It is the read-side counterpart of the write controller and shares the same Gray-coded pointer protocol across the clock-domain crossing.

---
 rtl/fifo_rd_ctrl.sv | 72 +++++++
 tb/tb_fifo_rd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, write-pointer
// synchronizer and registered empty / fill level / underflow status.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("fifo_rd_ctrl: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          rd_fire;

  assign wq_gray = sync_q[SYNC_STAGES-1];
  assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

  always_comb begin
    rd_fire      = rd_en & ~empty;
    rd_bin_next  = rd_bin + PW'(rd_fire);
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    // bit i of the binary value is the XOR of all Gray bits at or above i
    wq_bin = '0;
    for (int i = 0; i < PW; i++) begin
      wq_bin[i] = ^(wq_gray >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      rd_count    <= '0;
      underflow   <= 1'b0;
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      // status looks at the post-read pointer so the last read empties at once
      empty       <= (rd_gray_next == wq_gray);
      rd_count    <= wq_bin - rd_bin_next;
      underflow   <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2):
// stimulus queues expectations per edge, a monitor compares after each edge.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] wr_ptr_gray = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic [4:0] rd_count;
  logic       underflow;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_ptr_gray(rd_ptr_gray),
    .empty      (empty),
    .rd_count   (rd_count),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] gray;
    logic [3:0] addr;
    logic       emp;
    logic [4:0] cnt;
    logic       uf;
    logic [4:0] m;
  } exp_t;

  localparam logic [4:0] M_G = 5'b00001;
  localparam logic [4:0] M_A = 5'b00010;
  localparam logic [4:0] M_E = 5'b00100;
  localparam logic [4:0] M_C = 5'b01000;
  localparam logic [4:0] M_U = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int scyc = 0;
  int mcyc = 0;

  // reference state: binary pointers as integers
  int m_rd = 0, m_s0 = 0, m_s1 = 0, m_cnt = 0, m_fires = 0;
  bit m_emp = 1'b1, m_uf = 1'b0;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic dir(input string nm, input logic [4:0] g,
                     input logic [3:0] a, input logic e,
                     input logic [4:0] c, input logic u,
                     input logic [4:0] m);
    exp_t x;
    x.cyc = scyc; x.name = nm; x.gray = g; x.addr = a;
    x.emp = e; x.cnt = c; x.uf = u; x.m = m;
    q.push_back(x);
  endtask

  task automatic step(input bit r, input bit en, input int w);
    exp_t x;
    int nrd;
    bit fire;
    rst = r;
    rd_en = en;
    wr_ptr_gray = g5(w);
    if (r) begin
      m_rd = 0; m_s0 = 0; m_s1 = 0;
      m_emp = 1'b1; m_cnt = 0; m_uf = 1'b0;
    end else begin
      fire = en && !m_emp;
      m_uf = en && m_emp;
      if (fire) m_fires++;
      nrd = (m_rd + int'(fire)) % 32;
      m_emp = (nrd == m_s1);
      m_cnt = (m_s1 - nrd + 32) % 32;
      m_rd = nrd;
      m_s1 = m_s0;
      m_s0 = w % 32;
    end
    x.cyc = scyc; x.name = "model"; x.gray = g5(m_rd);
    x.addr = 4'(m_rd % 16); x.emp = m_emp; x.cnt = 5'(m_cnt);
    x.uf = m_uf; x.m = M_ALL;
    q.push_back(x);
    @(posedge clk);
    scyc++;
    @(negedge clk);
  endtask

  // monitor: compare every expectation queued for this edge
  initial begin
    exp_t x;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= mcyc) begin
        x = q.pop_front();
        bad = (x.cyc != mcyc);
        if (x.m[0] && rd_ptr_gray !== x.gray) bad = 1'b1;
        if (x.m[1] && rd_addr !== x.addr) bad = 1'b1;
        if (x.m[2] && empty !== x.emp) bad = 1'b1;
        if (x.m[3] && rd_count !== x.cnt) bad = 1'b1;
        if (x.m[4] && underflow !== x.uf) bad = 1'b1;
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL %s cyc=%0d got g=%b a=%0d e=%b c=%0d u=%b want g=%b a=%0d e=%b c=%0d u=%b mask=%b",
                   x.name, mcyc, rd_ptr_gray, rd_addr, empty, rd_count,
                   underflow, x.gray, x.addr, x.emp, x.cnt, x.uf, x.m);
        end
      end
      mcyc++;
    end
  end

  initial begin
    int w;
    int guard;
    logic [31:0] pat;
    pat = 32'hB6D5_A3C9;

    // 1: reset held two cycles with rd_en high
    dir("rst1", 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, M_ALL);
    step(1, 1, 0);
    dir("rst2", 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, M_ALL);
    step(1, 1, 0);

    // 2: single write visible exactly three edges later, then one read
    step(0, 0, 1);
    dir("vis_early", 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, M_E | M_C);
    step(0, 0, 1);
    dir("vis", 5'd0, 4'd0, 1'b0, 5'd1, 1'b0, M_E | M_C);
    step(0, 0, 1);
    dir("rd1", 5'b00001, 4'd1, 1'b1, 5'd0, 1'b0, M_ALL);
    step(0, 1, 1);

    // 3: underflow for three cycles, nothing else moves
    for (int i = 0; i < 3; i++) begin
      dir("underflow", 5'b00001, 4'd1, 1'b1, 5'd0, 1'b1, M_ALL);
      step(0, 1, 1);
    end

    // 4: full level and drain from a fresh reset
    step(1, 0, 0);
    step(0, 0, 16);
    step(0, 0, 16);
    dir("full", 5'd0, 4'd0, 1'b0, 5'd16, 1'b0, M_ALL);
    step(0, 0, 16);
    for (int i = 0; i < 16; i++) begin
      dir("drain", 5'd0, 4'd0, (i == 15), 5'(15 - i), 1'b0, M_E | M_C);
      step(0, 1, 16);
    end
    dir("drain_end", 5'b11000, 4'd0, 1'b1, 5'd0, 1'b0, M_ALL);
    step(0, 0, 16);

    // 5: wrap-around with a fixed irregular read pattern
    step(1, 0, 0);
    w = 0;
    m_fires = 0;
    guard = 0;
    while (m_fires < 40 && guard < 400) begin
      if (w < 40 && (w - m_fires) < 14) w++;
      step(0, pat[guard % 32] && !m_emp && m_fires < 40, w);
      guard++;
    end
    dir("wrap_end", 5'b01100, 4'd8, 1'b1, 5'd0, 1'b0, M_ALL);
    step(0, 0, w);
    checks++;
    if (m_fires != 40 || w != 40) begin
      failures++;
      $display("FAIL wrap_budget reads=%0d writes=%0d want 40/40",
               m_fires, w);
    end

    // 6: reset mid-stream with rd_count 7 and rd_en high
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 7);
    dir("pre_rst", 5'd0, 4'd0, 1'b0, 5'd7, 1'b0, M_E | M_C);
    step(0, 0, 7);
    dir("mid_rst", 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, M_ALL);
    step(1, 1, 7);
    step(0, 0, 3);
    dir("post_rst_early", 5'd0, 4'd0, 1'b1, 5'd0, 1'b0, M_E | M_C);
    step(0, 0, 3);
    dir("post_rst_vis", 5'd0, 4'd0, 1'b0, 5'd3, 1'b0, M_E | M_C);
    step(0, 0, 3);

    step(0, 0, 3);
    step(0, 0, 3);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue left=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
